sdram_init_seq: RTL and testbench
=================================

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low: sdram_clk and sdram_resetn.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- NOP_CYC, 500: NOP cycles after reset release (minimum 1).
- TRP_CYC, 2: NOP cycles after PRECHARGE (minimum 1).
- TRFC_CYC, 7: NOP cycles after each AUTO REFRESH (minimum 1).
- TMRD_CYC, 2: NOP cycles after a mode-register write (minimum 1).
- SDR_AW, 13: SDRAM address width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- sdram_clk, in, 1: the only clock.
- sdram_resetn, in, 1: synchronous reset, active low.
- init_req, in, 1: re-initialisation request pulse.
- cfg_sdr_mode_reg, in, SDR_AW: value written by MRS.
- cfg_sdr_ext_mode_reg, in, SDR_AW: value written by EMRS (used only when SDR_INIT_EXT_MODE_EN is defined).
- sdr_cke, out, 1: clock enable to the SDRAM.
- sdr_cs_n, out, 1: chip select.
- sdr_ras_n, out, 1: row address strobe.
- sdr_cas_n, out, 1: column address strobe.
- sdr_we_n, out, 1: write enable.
- sdr_ba, out, 2: bank address.
- sdr_addr, out, SDR_AW: address bus.
- init_done, out, 1: initialisation complete; the controller may issue traffic.
- init_busy, out, 1: a sequence is in progress.

Function
REQ-004 All outputs SHALL be registered; the command for a state appears one cycle after that state is entered.
REQ-005 Command encodings SHALL be, as ras_n/cas_n/we_n with cs_n=0:
- NOP = HHH, PRECHARGE = LHL, AUTO REFRESH = LLH, MRS/EMRS = LLL.
- An active command SHALL last exactly one cycle; NOP SHALL be driven in every other cycle.
REQ-006 The state machine SHALL have these states: WAIT_NOP, PRE, WAIT_TRP, REF1, WAIT_RFC1, REF2, WAIT_RFC2, MRS, WAIT_MRD, [EMRS, WAIT_EMRD], DONE.
REQ-007 Transitions SHALL be:
- WAIT_NOP -> PRE after NOP_CYC cycles.
- PRE -> WAIT_TRP; WAIT_TRP -> REF1 after TRP_CYC cycles.
- REF1 -> WAIT_RFC1; WAIT_RFC1 -> REF2 after TRFC_CYC cycles.
- REF2 -> WAIT_RFC2; WAIT_RFC2 -> MRS after TRFC_CYC cycles.
- MRS -> WAIT_MRD; WAIT_MRD -> DONE (or -> EMRS) after TMRD_CYC cycles.
- EMRS -> WAIT_EMRD -> DONE after TMRD_CYC cycles.
REQ-008 The wait counter SHALL be 16 bits, loaded on state entry and decremented to zero; values above 65535 are illegal.
REQ-009 Timing from the first cycle after reset release (cycle 0), with output cycle numbers:
- PRECHARGE at cycle NOP_CYC.
- REF1 at NOP_CYC+1+TRP_CYC.
- REF2 at REF1+1+TRFC_CYC.
- MRS at REF2+1+TRFC_CYC.
- init_done rises at MRS+1+TMRD_CYC.
REQ-010 PRECHARGE SHALL drive sdr_addr[10]=1 (all banks), with all other address bits and sdr_ba at 0.
REQ-011 MRS SHALL drive sdr_ba=0 and sdr_addr=cfg_sdr_mode_reg, sampled in the MRS state.
REQ-012 sdr_addr and sdr_ba SHALL be 0 during NOP cycles.
REQ-013 init_done SHALL be 1 only in DONE; init_busy SHALL be exactly its inverse.
REQ-014 In DONE the block SHALL drive NOP with sdr_cs_n=1.
REQ-015 init_req=1 in DONE SHALL move the machine to WAIT_NOP next cycle:
- init_done falls and the full sequence repeats.
- sdr_cke stays 1.
REQ-016 init_req SHALL be ignored while init_busy=1.

Reset
REQ-017 While sdram_resetn=0 at a rising edge, the next-cycle values SHALL be:
- sdr_cke=0, sdr_cs_n=1, sdr_ras_n=1, sdr_cas_n=1, sdr_we_n=1.
- sdr_ba=0, sdr_addr=0.
- init_done=0, init_busy=1.
- state=WAIT_NOP, counter=NOP_CYC.
REQ-018 sdr_cke SHALL rise in the first cycle after reset release.
REQ-019 A reset asserted mid-sequence (any state) SHALL abort the sequence with no partial command, then restart from WAIT_NOP.

Configuration
REQ-020 Macro SDR_INIT_EXT_MODE_EN:
- Defined: after WAIT_MRD the machine SHALL issue EMRS with sdr_ba=2'b10 and sdr_addr=cfg_sdr_ext_mode_reg, then wait TMRD_CYC cycles before DONE (init_done delayed by 1+TMRD_CYC).
- Undefined: the EMRS and WAIT_EMRD states and cfg_sdr_ext_mode_reg usage SHALL be absent; WAIT_MRD goes directly to DONE.

Verification
REQ-021 Defaults, release reset at cycle 0 -> expected outputs:
- NOP cycles 0-499, PRECHARGE with addr[10]=1 at cycle 500.
- REF at 503 and 511, MRS at 519, init_done=1 at 522.
REQ-022 cfg_sdr_mode_reg=13'h0033 -> MRS cycle shows sdr_addr=13'h0033, sdr_ba=0, ras/cas/we=LLL.
REQ-023 Reset asserted at cycle 505 (during WAIT_RFC1), released at 510 -> NOP only until PRECHARGE at cycle 1010, relative to the original cycle 0 (500 cycles after release).
REQ-024 init_req pulse at cycle 530 -> init_done=0 at 531; PRECHARGE at 1031.
REQ-025 init_req pulse at cycle 300 -> ignored; PRECHARGE stays at 500.
REQ-026 With SDR_INIT_EXT_MODE_EN and cfg_sdr_ext_mode_reg=13'h0020 -> EMRS at cycle 522 with ba=2'b10, addr=13'h0020; init_done at 525.

Source files
------------

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, two AUTO REFRESH, MRS, then DONE.
// Define SDR_INIT_EXT_MODE_EN to add an EMRS (BA=2'b10) after the MRS wait.
module sdram_init_seq #(
   parameter int unsigned NOP_CYC  = 500,
   parameter int unsigned TRP_CYC  = 2,
   parameter int unsigned TRFC_CYC = 7,
   parameter int unsigned TMRD_CYC = 2,
   parameter int unsigned SDR_AW   = 13
) (
   input  logic              sdram_clk,
   input  logic              sdram_resetn,
   input  logic              init_req,
   input  logic [SDR_AW-1:0] cfg_sdr_mode_reg,
   input  logic [SDR_AW-1:0] cfg_sdr_ext_mode_reg,
   output logic              sdr_cke,
   output logic              sdr_cs_n,
   output logic              sdr_ras_n,
   output logic              sdr_cas_n,
   output logic              sdr_we_n,
   output logic [1:0]        sdr_ba,
   output logic [SDR_AW-1:0] sdr_addr,
   output logic              init_done,
   output logic              init_busy
);

   typedef enum logic [3:0] {
      StWaitNop,
      StPre,
      StWaitTrp,
      StRef1,
      StWaitRfc1,
      StRef2,
      StWaitRfc2,
      StMrs,
      StWaitMrd,
`ifdef SDR_INIT_EXT_MODE_EN
      StEmrs,
      StWaitEmrd,
`endif
      StDone
   } state_e;

   localparam logic [15:0] NopLd  = 16'(NOP_CYC);
   localparam logic [15:0] TrpLd  = 16'(TRP_CYC);
   localparam logic [15:0] TrfcLd = 16'(TRFC_CYC);
   localparam logic [15:0] TmrdLd = 16'(TMRD_CYC);

   // {ras_n, cas_n, we_n}
   localparam logic [2:0] CmdNop = 3'b111;
   localparam logic [2:0] CmdPre = 3'b010;
   localparam logic [2:0] CmdRef = 3'b001;
   localparam logic [2:0] CmdMrs = 3'b000;

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              wait_done;
   logic              cs_n_d, cs_n_q;
   logic [2:0]        cmd_d, cmd_q;
   logic [1:0]        ba_d, ba_q;
   logic [SDR_AW-1:0] addr_d, addr_q;
   logic              cke_q, done_q, busy_q;

`ifndef SDR_INIT_EXT_MODE_EN
   logic unused_ext_mode;
   assign unused_ext_mode = ^cfg_sdr_ext_mode_reg;
`endif

   // Counter is loaded on entry to a wait state; the wait ends when it reaches 1 so the
   // state is held for exactly the loaded number of cycles.
   assign wait_done = (cnt_q <= 16'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
      cs_n_d  = 1'b0;
      cmd_d   = CmdNop;
      ba_d    = 2'b00;
      addr_d  = '0;
      unique case (state_q)
         StWaitNop:  if (wait_done) state_d = StPre;
         StPre: begin
            state_d    = StWaitTrp;
            cnt_d      = TrpLd;
            cmd_d      = CmdPre;
            addr_d[10] = 1'b1;
         end
         StWaitTrp:  if (wait_done) state_d = StRef1;
         StRef1: begin
            state_d = StWaitRfc1;
            cnt_d   = TrfcLd;
            cmd_d   = CmdRef;
         end
         StWaitRfc1: if (wait_done) state_d = StRef2;
         StRef2: begin
            state_d = StWaitRfc2;
            cnt_d   = TrfcLd;
            cmd_d   = CmdRef;
         end
         StWaitRfc2: if (wait_done) state_d = StMrs;
         StMrs: begin
            state_d = StWaitMrd;
            cnt_d   = TmrdLd;
            cmd_d   = CmdMrs;
            addr_d  = cfg_sdr_mode_reg;
         end
`ifdef SDR_INIT_EXT_MODE_EN
         StWaitMrd:  if (wait_done) state_d = StEmrs;
         StEmrs: begin
            state_d = StWaitEmrd;
            cnt_d   = TmrdLd;
            cmd_d   = CmdMrs;
            ba_d    = 2'b10;
            addr_d  = cfg_sdr_ext_mode_reg;
         end
         StWaitEmrd: if (wait_done) state_d = StDone;
`else
         StWaitMrd:  if (wait_done) state_d = StDone;
`endif
         StDone: begin
            cs_n_d = 1'b1;
            if (init_req) begin
               state_d = StWaitNop;
               cnt_d   = NopLd;
            end
         end
         default: begin
            state_d = StWaitNop;
            cnt_d   = NopLd;
         end
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state_q <= StWaitNop;
         cnt_q   <= NopLd;
         cke_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         cmd_q   <= CmdNop;
         ba_q    <= 2'b00;
         addr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cke_q   <= 1'b1;
         cs_n_q  <= cs_n_d;
         cmd_q   <= cmd_d;
         ba_q    <= ba_d;
         addr_q  <= addr_d;
         done_q  <= (state_q == StDone);
         busy_q  <= (state_q != StDone);
      end
   end

   assign sdr_cke   = cke_q;
   assign sdr_cs_n  = cs_n_q;
   assign sdr_ras_n = cmd_q[2];
   assign sdr_cas_n = cmd_q[1];
   assign sdr_we_n  = cmd_q[0];
   assign sdr_ba    = ba_q;
   assign sdr_addr  = addr_q;
   assign init_done = done_q;
   assign init_busy = busy_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: full-sequence timing, ignored/accepted init_req,
// mid-sequence reset. Expectations follow SDR_INIT_EXT_MODE_EN when it is defined.
module tb_sdram_init_seq;

   logic        clk;
   logic        resetn;
   logic        init_req;
   logic [12:0] mode_reg;
   logic [12:0] ext_mode_reg;
   logic        cke, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic        done, busy;

   int err_cnt = 0;
   int chk_cnt = 0;

   sdram_init_seq dut (
      .sdram_clk            (clk),
      .sdram_resetn         (resetn),
      .init_req             (init_req),
      .cfg_sdr_mode_reg     (mode_reg),
      .cfg_sdr_ext_mode_reg (ext_mode_reg),
      .sdr_cke              (cke),
      .sdr_cs_n             (cs_n),
      .sdr_ras_n            (ras_n),
      .sdr_cas_n            (cas_n),
      .sdr_we_n             (we_n),
      .sdr_ba               (ba),
      .sdr_addr             (addr),
      .init_done            (done),
      .init_busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SDR_INIT_EXT_MODE_EN
   localparam int DoneT = 525;
`else
   localparam int DoneT = 522;
`endif

   task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got cke/cs/ras/cas/we/ba/addr/done/busy=%b_%b%b%b%b_%b_%h_%b%b, want %b_%b%b%b%b_%b_%h_%b%b",
                  tag, got[21], got[20], got[19], got[18], got[17], got[16:15], got[14:2],
                  got[1], got[0], exp[21], exp[20], exp[19], exp[18], exp[17], exp[16:15],
                  exp[14:2], exp[1], exp[0]);
      end
   endtask

   // Expected {cke, cs_n, ras_n, cas_n, we_n, ba, addr, done, busy} at sequence cycle t.
   function automatic logic [21:0] exp_vec(input int t, input bit in_rst);
      logic [2:0]  cmd;
      logic        cs, dn;
      logic [1:0]  b;
      logic [12:0] a;
      if (in_rst) return {1'b0, 1'b1, 3'b111, 2'b00, 13'h0000, 1'b0, 1'b1};
      cmd = 3'b111; cs = 1'b0; b = 2'b00; a = 13'h0000; dn = 1'b0;
      if (t >= DoneT) begin
         cs = 1'b1;
         dn = 1'b1;
      end else if (t == 500) begin
         cmd = 3'b010;
         a   = 13'h0400;
      end else if (t == 503 || t == 511) begin
         cmd = 3'b001;
      end else if (t == 519) begin
         cmd = 3'b000;
         a   = 13'h0033;
      end
`ifdef SDR_INIT_EXT_MODE_EN
      else if (t == 522) begin
         cmd = 3'b000;
         b   = 2'b10;
         a   = 13'h0020;
      end
`endif
      return {1'b1, cs, cmd, b, a, dn, ~dn};
   endfunction

   function automatic logic [21:0] got_vec();
      return {cke, cs_n, ras_n, cas_n, we_n, ba, addr, done, busy};
   endfunction

   initial begin
      int  seq_start;
      bit  in_rst;

      resetn       = 1'b0;
      init_req     = 1'b0;
      mode_reg     = 13'h0033;
      ext_mode_reg = 13'h0020;

      // Phase A: power-up, ignored init_req at 300, accepted init_req at 530.
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset", got_vec(), exp_vec(0, 1'b1));
      resetn    = 1'b1;
      seq_start = 0;
      for (int c = 0; c <= 1070; c++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("A%0d", c), got_vec(), exp_vec(c - seq_start, 1'b0));
         init_req = (c == 299) || (c == 529);
         if (c == 530) seq_start = 531;
      end

      // Phase B: reset during WAIT_RFC1 (sampled 505..509), restart counted from 510.
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset2", got_vec(), exp_vec(0, 1'b1));
      resetn    = 1'b1;
      seq_start = 0;
      in_rst    = 1'b0;
      for (int c = 0; c <= 1045; c++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("B%0d", c), got_vec(), exp_vec(c - seq_start, in_rst));
         if (c == 504) begin
            resetn = 1'b0;
            in_rst = 1'b1;
         end
         if (c == 509) begin
            resetn    = 1'b1;
            in_rst    = 1'b0;
            seq_start = 510;
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
